// File: rtl/jtpang_colmix_if.sv
// CPU byte port of the jtpang_colmix palette: address, write data, write strobe and read-back.
interface jtpang_colmix_if;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        pal_we;
  logic [7:0]  pal_dout;

  modport master (output cpu_addr, output cpu_dout, output pal_we, input pal_dout);
  modport slave  (input cpu_addr, input cpu_dout, input pal_we, output pal_dout);
endinterface

// File: rtl/jtpang_colmix.sv
// Final colour mixer: layer priority, 2048-entry palette lookup and blanked 4-4-4 RGB output.
// Optional layer enables via `define JTPANG_COLMIX_GFXEN_EN (default build ignores gfx_en).
module jtpang_colmix #(
  parameter int BLANK_DLY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic             LHBL,
  input  logic             LVBL,
  input  logic [7:0]       obj_pxl,
  input  logic [9:0]       chr_pxl,
  jtpang_colmix_if.slave   cpu,
  input  logic [1:0]       gfx_en,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             LHBL_dly,
  output logic             LVBL_dly
);

  // even byte {G,B} and odd nibble R, split so byte writes need no read-modify-write
  logic [7:0]  pal_even_r [0:2047];
  logic [3:0]  pal_odd_r  [0:2047];

  logic [10:0] cpu_ent_s;
  logic        obj_opaque_s;
  logic [9:0]  chr_eff_s;
  logic [10:0] idx_s;
  logic [10:0] idx_r;
  logic [11:0] pal_rd_r;
  logic [BLANK_DLY-2:0] lhbl_sr_r;
  logic [BLANK_DLY-2:0] lvbl_sr_r;

  assign cpu_ent_s = cpu.cpu_addr[11:1];

`ifdef JTPANG_COLMIX_GFXEN_EN
  // Layer enables: a disabled char layer points at the 0x7FF backdrop entry
  always_comb begin
    obj_opaque_s = gfx_en[1] && (obj_pxl[3:0] != 4'hF);
    if (gfx_en[0]) begin
      chr_eff_s = chr_pxl;
    end else begin
      chr_eff_s = 10'h3FF;
    end
  end
`else
  logic unused_gfx_en_s;

  // Both layers always enabled
  always_comb begin
    obj_opaque_s    = (obj_pxl[3:0] != 4'hF);
    chr_eff_s       = chr_pxl;
    unused_gfx_en_s = ^gfx_en;
  end
`endif

  // Layer priority: opaque objects win, otherwise the char entry (backdrop included)
  always_comb begin
    if (obj_opaque_s) begin
      idx_s = {3'b000, obj_pxl};
    end else begin
      idx_s = {1'b1, chr_eff_s};
    end
  end

  // CPU write port of the palette RAMs; contents survive reset
  always_ff @(posedge clk) begin
    if (cpu.pal_we) begin
      if (cpu.cpu_addr[0]) begin
        pal_odd_r[cpu_ent_s] <= cpu.cpu_dout[3:0];
      end else begin
        pal_even_r[cpu_ent_s] <= cpu.cpu_dout;
      end
    end
  end

  // CPU read-back, registered every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu.pal_dout <= 8'h00;
    end else if (cpu.cpu_addr[0]) begin
      cpu.pal_dout <= {4'h0, pal_odd_r[cpu_ent_s]};
    end else begin
      cpu.pal_dout <= pal_even_r[cpu_ent_s];
    end
  end

  // Video pipeline: S1 index, S2 palette read (old data on a same-clk write), S3 blanked RGB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= 11'h000;
      pal_rd_r  <= 12'h000;
      lhbl_sr_r <= {(BLANK_DLY-1){1'b0}};
      lvbl_sr_r <= {(BLANK_DLY-1){1'b0}};
      LHBL_dly  <= 1'b0;
      LVBL_dly  <= 1'b0;
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
    end else if (pxl_cen) begin
      idx_r     <= idx_s;
      pal_rd_r  <= {pal_odd_r[idx_r], pal_even_r[idx_r]};
      lhbl_sr_r <= {lhbl_sr_r[BLANK_DLY-3:0], LHBL};
      lvbl_sr_r <= {lvbl_sr_r[BLANK_DLY-3:0], LVBL};
      LHBL_dly  <= lhbl_sr_r[BLANK_DLY-2];
      LVBL_dly  <= lvbl_sr_r[BLANK_DLY-2];
      if (lhbl_sr_r[BLANK_DLY-2] && lvbl_sr_r[BLANK_DLY-2]) begin
        {red, green, blue} <= pal_rd_r;
      end else begin
        {red, green, blue} <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_jtpang_colmix.sv
// Scoreboard bench for jtpang_colmix: stimulus pushes expected pixels/read-backs, a monitor pops and compares.
module tb_jtpang_colmix;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pxl_cen = 1'b0;
  logic       LHBL, LVBL;
  logic [7:0] obj_pxl;
  logic [9:0] chr_pxl;
  logic [1:0] gfx_en;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtpang_colmix_if bus ();

  jtpang_colmix #(.BLANK_DLY(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .obj_pxl  (obj_pxl),
    .chr_pxl  (chr_pxl),
    .cpu      (bus.slave),
    .gfx_en   (gfx_en),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #5 clk = ~clk;

  // pixel enable: one clk in four
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      pxl_cen = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
    end
  end

  typedef struct {
    int          due;
    logic [13:0] exp;
    logic [63:0] name;
  } item_t;

  item_t vid_q[$];
  item_t rb_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    tk = 0;
  logic  last_cen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_cen <= pxl_cen;
    if (pxl_cen) tk <= tk + 1;
  end

  task automatic chk(input logic [63:0] name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %0s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic missed(input logic [63:0] name);
    tests++;
    fails++;
    $display("FAIL %0s: check slot passed without comparison", name);
  endtask

  // monitor: read-back is due on a clk count, video on a pixel tick count
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (rb_q.size() > 0 && rb_q[0].due <= cyc) begin
        it = rb_q.pop_front();
        if (it.due < cyc) missed(it.name);
        else chk(it.name, {6'h00, bus.pal_dout}, it.exp);
      end
      if (last_cen) begin
        while (vid_q.size() > 0 && vid_q[0].due <= tk) begin
          it = vid_q.pop_front();
          if (it.due < tk) missed(it.name);
          else chk(it.name, {red, green, blue, LHBL_dly, LVBL_dly}, it.exp);
        end
      end
    end
  end

  task automatic tick_wait();
    @(posedge clk);
    while (!pxl_cen) @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [7:0] o, input logic [9:0] c, input logic h, input logic v,
                    input logic [11:0] rgb, input logic [63:0] nm);
    obj_pxl = o;
    chr_pxl = c;
    LHBL    = h;
    LVBL    = v;
    vid_q.push_back('{due: tk + 3, exp: {rgb, h, v}, name: nm});
    tick_wait();
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    bus.pal_we   = 1'b1;
    @(posedge clk);
    #1;
    bus.pal_we   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] d, input logic [63:0] nm);
    bus.cpu_addr = a;
    rb_q.push_back('{due: cyc + 1, exp: {6'h00, d}, name: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((vid_q.size() + rb_q.size()) > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if ((vid_q.size() + rb_q.size()) > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d checks never reached", vid_q.size() + rb_q.size());
      vid_q.delete();
      rb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; LHBL = 1'b0; LVBL = 1'b0;
    obj_pxl = 8'h00; chr_pxl = 10'h000; gfx_en = 2'b11;
    bus.cpu_addr = 12'h000; bus.cpu_dout = 8'h00; bus.pal_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {2'b00, red, green, blue}, 14'h0000);
    chk("rst_blnk", {12'h000, LHBL_dly, LVBL_dly}, 14'h0000);
    chk("rst_dout", {6'h00, bus.pal_dout}, 14'h0000);
    rst_n = 1'b1;

    // palette setup: entry = {odd R, even {G,B}}
    wr(12'h000, 8'hA5); wr(12'h001, 8'hF3);            // 0x000 = 3A5
    rd(12'h001, 8'h03, "rb_odd");
    rd(12'h000, 8'hA5, "rb_even");
    wr(12'h80A, 8'h23); wr(12'h80B, 8'h01);            // 0x405 = 123
    wr(12'h024, 8'hED); wr(12'h025, 8'h0F);            // 0x012 = FED
    wr(12'hFFE, 8'h9C); wr(12'hFFF, 8'h0B);            // 0x7FF = B9C
    wr(12'h83E, 8'h67); wr(12'h83F, 8'h05);            // 0x41F = 567
    wr(12'h824, 8'h44); wr(12'h825, 8'h02);            // 0x412 = 244
    rd(12'h80B, 8'h01, "rb_405r");
    rd(12'h824, 8'h44, "rb_412e");

    tick_wait();
    px(8'h00, 10'h000, 1'b1, 1'b1, 12'h3A5, "obj0");
    px(8'h1F, 10'h005, 1'b1, 1'b1, 12'h123, "chr405");
    px(8'h12, 10'h005, 1'b1, 1'b1, 12'hFED, "obj12");
    px(8'h1F, 10'h01F, 1'b1, 1'b1, 12'h567, "backdrop");
    px(8'h12, 10'h005, 1'b0, 1'b1, 12'h000, "hblank");
    px(8'h12, 10'h005, 1'b1, 1'b1, 12'hFED, "hb_after");
    px(8'h12, 10'h005, 1'b1, 1'b0, 12'h000, "vblank");
`ifdef JTPANG_COLMIX_GFXEN_EN
    gfx_en = 2'b01; px(8'h12, 10'h012, 1'b1, 1'b1, 12'h244, "gfx01");
    gfx_en = 2'b00; px(8'h12, 10'h012, 1'b1, 1'b1, 12'hB9C, "gfx00");
    gfx_en = 2'b10; px(8'h1F, 10'h012, 1'b1, 1'b1, 12'hB9C, "gfx10");
`else
    gfx_en = 2'b00; px(8'h12, 10'h012, 1'b1, 1'b1, 12'hFED, "gfx_ign");
    gfx_en = 2'b00; px(8'h1F, 10'h012, 1'b1, 1'b1, 12'h244, "gfx_ign2");
`endif
    gfx_en = 2'b11;
    drain();

    // collision: write 0x405 even byte on the clk the video port reads it
    obj_pxl = 8'h1F; chr_pxl = 10'h005; LHBL = 1'b1; LVBL = 1'b1;
    vid_q.push_back('{due: tk + 3, exp: {12'h123, 2'b11}, name: "coll_old"});
    tick_wait();
    vid_q.push_back('{due: tk + 3, exp: {12'h178, 2'b11}, name: "coll_new"});
    do begin
      @(negedge clk);
      #1;
    end while (!pxl_cen);
    bus.cpu_addr = 12'h80A; bus.cpu_dout = 8'h78; bus.pal_we = 1'b1;
    @(posedge clk);
    #1;
    bus.pal_we = 1'b0;
    px(8'h1F, 10'h005, 1'b1, 1'b1, 12'h178, "coll_nxt");
    drain();

    // reset mid-line with pixels flowing
    bus.cpu_addr = 12'h000;
    obj_pxl = 8'h12; chr_pxl = 10'h005; LHBL = 1'b1; LVBL = 1'b1;
    repeat (5) tick_wait();
    chk("pre_rst", {red, green, blue, LHBL_dly, LVBL_dly}, {12'hFED, 2'b11});
    chk("pre_dout", {6'h00, bus.pal_dout}, 14'h00A5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rgb", {2'b00, red, green, blue}, 14'h0000);
    chk("mid_blnk", {12'h000, LHBL_dly, LVBL_dly}, 14'h0000);
    chk("mid_dout", {6'h00, bus.pal_dout}, 14'h0000);
    repeat (2) tick_wait();
    rst_n = 1'b1;
    vid_q.push_back('{due: tk + 1, exp: 14'h0000, name: "rel_t1"});
    vid_q.push_back('{due: tk + 2, exp: 14'h0000, name: "rel_t2"});
    vid_q.push_back('{due: tk + 3, exp: {12'hFED, 2'b11}, name: "rel_t3"});
    rd(12'h001, 8'h03, "rel_rb");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtpang_colmix.md
Name: jtpang_colmix

Overview:
- Final pixel stage, directly downstream of the object line buffer and the character/tilemap layer.
- Each pixel clock it picks the visible layer, looks the colour up in a CPU-writable palette RAM, and outputs blanked 4-bit-per-channel RGB to the video output.
- Owns the 2048-entry palette and its CPU byte port, including read-back.

Parameters:
- BLANK_DLY, 3: pipeline depth in pxl_cen ticks. It is applied to LHBL/LVBL so blanking stays aligned with RGB. Fixed at 3; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- pxl_cen  in  1  pixel clock enable, one clk wide
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- obj_pxl  in  8  object pixel {pal[3:0], col[3:0]}
- chr_pxl  in  10  character pixel {pal[5:0], col[3:0]}
- cpu_addr  in  12  palette byte address; bit 0 selects the byte
- cpu_dout  in  8  CPU write data
- pal_we  in  1  palette write strobe, one clk per byte
- pal_dout  out  8  palette read-back byte
- gfx_en  in  2  layer enable, bit0 = char, bit1 = obj; active only with the optional feature
- red, green, blue  out  4 each  colour outputs
- LHBL_dly, LVBL_dly  out  1 each  delayed blanking signals

Behaviour:
- Reset (rst_n low, asynchronous):
  - red, green, blue and pal_dout = 0.
  - LHBL_dly and LVBL_dly = 0.
  - All pipeline registers = 0.
  - Palette RAM contents are not cleared.
- Palette RAM:
  - 2048 x 12-bit entries, stored as an even byte {G, B} and an odd byte {4'h0, R}.
  - Implemented as two dual-port RAMs: port 0 for the CPU, port 1 for video.
  - Byte address A maps to entry A[11:1]; A[0] = 0 selects the even byte, A[0] = 1 the odd byte.
- CPU writes: when pal_we is high, the addressed byte is written on that clk edge.
  - Bits [7:4] of odd-byte writes are discarded; odd-byte read-back returns 4'h0 in [7:4].
- CPU read-back: pal_dout is registered and shows the byte at cpu_addr one clk later, on every clk regardless of pal_we.
  - A write followed by a read of the same address on the next clk returns the new data.
- Pipeline: every stage advances only on pxl_cen.
  - S1, layer select:
    - The object pixel is transparent when obj_pxl[3:0] = 4'hF; the character pixel is transparent when chr_pxl[3:0] = 4'hF.
    - If the object pixel is opaque, index = {3'b000, obj_pxl}, i.e. entries 0x000-0x0FF.
    - Otherwise index = {1'b1, chr_pxl}, i.e. entries 0x400-0x7FF, even when the character pixel is transparent (its col 4'hF entry is the backdrop).
    - Entries 0x100-0x3FF are CPU-accessible only.
  - S2: video port reads the palette at the index.
  - S3: RGB registered. Output is 0 whenever the S3-aligned LHBL_dly or LVBL_dly is 0.
- Latency: obj_pxl/chr_pxl sampled at pxl_cen tick N appear on RGB at tick N+3. LHBL/LVBL are delayed by the same 3 ticks into LHBL_dly/LVBL_dly.
- Write/read collision: when a CPU write hits the entry being read by video in the same clk, video gets the old value. The new value is visible from the next pixel.
- No clk without pxl_cen changes the video outputs.
- Reset mid-line: outputs go to 0 at once. Because LHBL_dly/LVBL_dly restart at 0, the first valid RGB after release appears 3 pxl_cen ticks after LHBL/LVBL go high.

Optional Feature:
- JTPANG_COLMIX_GFXEN_EN defined:
  - gfx_en[1] = 0 forces the object pixel transparent.
  - gfx_en[0] = 0 forces chr_pxl to 10'h3FF, so the character layer reads entry 0x7FF.
  - Applied in S1.
- Not defined: gfx_en is ignored and both layers are always enabled.

Test Plan:
- Write bytes 0x000 = 8'hA5 and 0x001 = 8'hF3; obj_pxl = 8'h00, LHBL = LVBL = 1 -> 3 ticks later R = 4'h3, G = 4'hA, B = 4'h5. Read-back of 0x001 = 8'h03.
- Palette entry 0x405 = 12'h123, entry 0x012 = 12'hFED; chr_pxl = 10'h005, obj_pxl = 8'h1F -> RGB = 12'h123. Then obj_pxl = 8'h12 -> RGB = 12'hFED.
- LHBL low for one tick while the pixel is non-black -> exactly one black pixel, 3 ticks later. LHBL_dly low at that same tick.
- CPU writes entry 0x405 in the same clk as the video read of it -> old value on that pixel, new value on the next pixel with the same input.
- rst_n low mid-line with pixels flowing -> RGB, LHBL_dly and pal_dout are 0 immediately. After release, palette contents are intact and the first valid colour appears 3 ticks after LHBL/LVBL go high.
- With JTPANG_COLMIX_GFXEN_EN defined, gfx_en = 2'b01 and obj_pxl = 8'h12 opaque -> character colour shown. gfx_en = 2'b00 -> entry 0x7FF shown.
